// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, result codes,
// and the digit count / counter width of the default 16-bit, 4-bit-digit build.
package cmp_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPARE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RES_EQ = 2'd0,
      RES_LT = 2'd1,
      RES_GT = 2'd2
   } res_t;

   localparam int WIDTH_DEF = 16;
   localparam int DIGIT_DEF = 4;
   localparam int NDIG      = WIDTH_DEF / DIGIT_DEF;
   localparam int CNTW      = $clog2(NDIG + 1);

endpackage

// File: rtl/serial_mag_comparator_digit_cmp.sv
// Combinational unsigned compare of one DIGIT-bit slice of each operand.
module digit_cmp #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   assign lt = (a < b);
   assign eq = (a == b);
   assign gt = (a > b);

endmodule

// File: rtl/serial_mag_comparator.sv
// Multi-cycle magnitude comparator: scans the latched operands one digit per
// cycle, MSB digit first, with optional early exit and signed mode.
module serial_mag_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int DIGIT      = 4,
   parameter int EARLY_EXIT = 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic                               signed_mode,
   input  logic [WIDTH-1:0]                   A,
   input  logic [WIDTH-1:0]                   B,
   output logic                               busy,
   output logic                               done,
   output logic                               A_s_B,
   output logic                               A_eq_B,
   output logic                               A_l_B,
   output logic [$clog2(WIDTH/DIGIT+1)-1:0]   cycles
);

   localparam int ND = WIDTH / DIGIT;
   localparam int CW = $clog2(ND + 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q;
   logic             sgn_q;
   logic [CW-1:0]    idx;
   res_t             dec;

   logic [WIDTH-1:0] a_sh, b_sh;
   logic [DIGIT-1:0] a_dig, b_dig;
   logic             d_lt, d_eq, d_gt;
   logic             last_dig, finish;
   res_t             res_now;

   // Digit select; in signed mode flipping the sign bit turns two's complement into offset binary
   always_comb begin
      a_sh  = a_q << (idx * DIGIT);
      b_sh  = b_q << (idx * DIGIT);
      a_dig = a_sh[WIDTH-1 -: DIGIT];
      b_dig = b_sh[WIDTH-1 -: DIGIT];
      if (sgn_q && (idx == '0)) begin
         a_dig[DIGIT-1] = ~a_dig[DIGIT-1];
         b_dig[DIGIT-1] = ~b_dig[DIGIT-1];
      end
   end

   digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
      .a  (a_dig),
      .b  (b_dig),
      .lt (d_lt),
      .eq (d_eq),
      .gt (d_gt)
   );

   // An earlier decision is sticky; only an undecided compare looks at this digit
   always_comb begin
      res_now = dec;
      if (dec == RES_EQ) begin
         if (d_lt)      res_now = RES_LT;
         else if (d_gt) res_now = RES_GT;
      end
   end

   assign last_dig = (idx == CW'(ND - 1));
   assign finish   = (state == S_COMPARE) && (last_dig || ((EARLY_EXIT != 0) && !d_eq));

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start)  state_nxt = S_COMPARE;
         S_COMPARE: if (finish) state_nxt = S_DONE;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         idx    <= '0;
         dec    <= RES_EQ;
         A_s_B  <= 1'b0;
         A_eq_B <= 1'b0;
         A_l_B  <= 1'b0;
         cycles <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && start) begin
            idx <= '0;
            dec <= RES_EQ;
         end else if (state == S_COMPARE) begin
            idx <= idx + CW'(1);
            dec <= res_now;
            if (finish) begin
               A_s_B  <= (res_now == RES_LT);
               A_eq_B <= (res_now == RES_EQ);
               A_l_B  <= (res_now == RES_GT);
               cycles <= idx + CW'(1);
            end
         end
      end
   end

   // Operand capture needs no reset: it is only read after a start has loaded it
   always_ff @(posedge clk) begin
      if (state == S_IDLE && start) begin
         a_q   <= A;
         b_q   <= B;
         sgn_q <= signed_mode;
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench: one early-exit and one full-scan comparator driven in parallel.
module tb_serial_mag_comparator;
   import cmp_pkg::*;

   logic             clk, rst_n, start, signed_mode;
   logic [15:0]      A, B;
   logic             busy1, done1, lt1, eq1, gt1;
   logic             busy2, done2, lt2, eq2, gt2;
   logic [CNTW-1:0]  cyc1, cyc2;

   int n_tests = 0;
   int n_fail  = 0;

   serial_mag_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) dut_ee (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
      .A(A), .B(B), .busy(busy1), .done(done1),
      .A_s_B(lt1), .A_eq_B(eq1), .A_l_B(gt1), .cycles(cyc1)
   );

   serial_mag_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) dut_full (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
      .A(A), .B(B), .busy(busy2), .done(done2),
      .A_s_B(lt2), .A_eq_B(eq2), .A_l_B(gt2), .cycles(cyc2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Called on a negedge with both DUTs idle; returns results and latency (0 = timeout).
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sg,
                         output logic [2:0] f1, output int c1, output int l1, output int n1,
                         output logic [2:0] f2, output int c2, output int l2);
      int lat;
      bit s1, s2;
      f1 = '0; f2 = '0; c1 = 0; c2 = 0; l1 = 0; l2 = 0; n1 = 0;
      s1 = 0; s2 = 0;
      A = a; B = b; signed_mode = sg; start = 1'b1;
      @(posedge clk); lat = 1;
      @(negedge clk); start = 1'b0;
      while (!(s1 && s2) && lat <= 20) begin
         if (done1) n1++;
         if (done1 && !s1) begin s1 = 1; l1 = lat; f1 = {lt1, eq1, gt1}; c1 = int'(cyc1); end
         if (done2 && !s2) begin s2 = 1; l2 = lat; f2 = {lt2, eq2, gt2}; c2 = int'(cyc2); end
         if (!(s1 && s2)) begin
            @(posedge clk); lat++;
            @(negedge clk);
         end
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sg;
      logic [2:0]  ef;   // {A_s_B, A_eq_B, A_l_B}
      int          ec;   // digits examined with early exit
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [2:0] f1, f2;
      int c1, l1, n1, c2, l2, nd;

      vecs[0]  = '{16'h1234, 16'h1234, 1'b0, 3'b010, 4};
      vecs[1]  = '{16'h9000, 16'h1000, 1'b0, 3'b001, 1};
      vecs[2]  = '{16'h9000, 16'h1000, 1'b1, 3'b100, 1};
      vecs[3]  = '{16'hFFFF, 16'hFFFE, 1'b1, 3'b001, 4};
      vecs[4]  = '{16'h7FFF, 16'h8000, 1'b1, 3'b001, 1};
      vecs[5]  = '{16'h0003, 16'h0005, 1'b0, 3'b100, 4};
      vecs[6]  = '{16'h8000, 16'h7FFF, 1'b0, 3'b001, 1};
      vecs[7]  = '{16'h8000, 16'h7FFF, 1'b1, 3'b100, 1};
      vecs[8]  = '{16'h1200, 16'h1300, 1'b0, 3'b100, 2};
      vecs[9]  = '{16'hABCD, 16'hABC0, 1'b1, 3'b001, 4};
      vecs[10] = '{16'hFFFF, 16'h0000, 1'b1, 3'b100, 1};
      vecs[11] = '{16'h0000, 16'h0000, 1'b1, 3'b010, 4};
      vecs[12] = '{16'h1234, 16'h1243, 1'b0, 3'b100, 3};

      rst_n = 1'b1; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_busy",  busy1, 0);
      check("reset_done",  done1, 0);
      check("reset_flags", {lt1, eq1, gt1}, 0);
      check("reset_cycles", cyc1, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sg, f1, c1, l1, n1, f2, c2, l2);
         check($sformatf("v%0d_flags", i),     f1, vecs[i].ef);
         check($sformatf("v%0d_cycles", i),    c1, vecs[i].ec);
         check($sformatf("v%0d_latency", i),   l1, vecs[i].ec + 1);
         check($sformatf("v%0d_done_cnt", i),  n1, 1);
         check($sformatf("v%0d_full_flags", i), f2, vecs[i].ef);
         check($sformatf("v%0d_full_cycles", i), c2, NDIG);
         check($sformatf("v%0d_full_latency", i), l2, NDIG + 1);
         check($sformatf("v%0d_idle_after", i), {busy1, done1, busy2, done2}, 0);
      end

      // start held high and operands changed while busy
      A = 16'h1234; B = 16'h1235; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      A = 16'hFFFF; B = 16'h0000; signed_mode = 1'b1;
      nd = 0; f1 = '0; c1 = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 5) start = 1'b0;
         if (done1) begin nd++; f1 = {lt1, eq1, gt1}; c1 = int'(cyc1); end
      end
      check("busy_start_done_cnt", nd, 1);
      check("busy_start_flags", f1, 3'b100);
      check("busy_start_cycles", c1, 4);
      check("busy_start_idle", busy1, 0);

      // asynchronous reset in the middle of COMPARE
      A = 16'h1234; B = 16'h1235; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy",   busy1, 0);
      check("abort_done",   done1, 0);
      check("abort_flags",  {lt1, eq1, gt1}, 0);
      check("abort_cycles", cyc1, 0);
      check("abort_full_busy", busy2, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      run_op(16'h0003, 16'h0005, 1'b0, f1, c1, l1, n1, f2, c2, l2);
      check("post_abort_flags",  f1, 3'b100);
      check("post_abort_cycles", c1, 4);
      check("post_abort_latency", l1, 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
